// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : full_adder                                                      |
// | Brief    : Registered WIDTH-bit ripple-carry full adder with signed        |
// |            overflow and valid tracking; 1-cycle latency.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = carry_in;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  endgenerate

  // Result registers hold on idle cycles; only out_valid tracks in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= w_s;
        carry_out <= w_c[WIDTH];
        overflow  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_full_adder                                                   |
// | Brief    : Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_full_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       co;
    logic       ov;
    logic       vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v1 = 1'b0, c1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;

  logic [0:0] sum1;
  logic       co1, ov1, vo1;
  logic [7:0] sum8;
  logic       co8, ov8, vo8;

  exp_t q1[$];
  exp_t q8[$];
  exp_t m1 = '0, m8 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(sum1), .carry_out(co1), .overflow(ov1), .out_valid(vo1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sum(sum8), .carry_out(co8), .overflow(ov8), .out_valid(vo8)
  );

  // Reference: plain integer arithmetic for the sum, signed range test for overflow.
  function automatic exp_t next_exp(int w, exp_t prev, logic rst, logic v,
                                    logic [7:0] a, logic [7:0] b, logic cin);
    exp_t e;
    int unsigned total;
    int sa, sb, ss;
    if (rst) return '0;
    if (!v) begin
      e = prev;
      e.vld = 1'b0;
      return e;
    end
    total = int'(a) + int'(b) + int'(cin);
    e.sum = 8'(total % (1 << w));
    e.co  = ((total >> w) % 2) == 1;
    sa = a[w-1] ? int'(a) - (1 << w) : int'(a);
    sb = b[w-1] ? int'(b) - (1 << w) : int'(b);
    ss = sa + sb + int'(cin);
    e.ov  = (ss > (1 << (w-1)) - 1) || (ss < -(1 << (w-1)));
    e.vld = 1'b1;
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(logic rst,
                       logic va, logic aa, logic ba, logic ca,
                       logic vb, logic [7:0] ab, logic [7:0] bb, logic cb);
    @(negedge clk);
    reset = rst;
    v1 = va; a1 = aa; b1 = ba; c1 = ca;
    v8 = vb; a8 = ab; b8 = bb; c8 = cb;
    m1 = next_exp(1, m1, rst, va, {7'b0, aa}, {7'b0, ba}, ca);
    m8 = next_exp(8, m8, rst, vb, ab, bb, cb);
    q1.push_back(m1);
    q8.push_back(m8);
  endtask

  // Monitor: compares one expected record per instance per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("w1_sum", {7'b0, sum1}, e.sum);
        chk("w1_cout", {7'b0, co1}, {7'b0, e.co});
        chk("w1_ovf", {7'b0, ov1}, {7'b0, e.ov});
        chk("w1_valid", {7'b0, vo1}, {7'b0, e.vld});
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("w8_sum", sum8, e.sum);
        chk("w8_cout", {7'b0, co8}, {7'b0, e.co});
        chk("w8_ovf", {7'b0, ov8}, {7'b0, e.ov});
        chk("w8_valid", {7'b0, vo8}, {7'b0, e.vld});
      end
    end
  end

  initial begin
    logic [2:0] t;
    // Reset for two cycles.
    cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    // Directed: single-bit basics back-to-back, 8-bit carry/overflow corners.
    cycle(0, 1, 1, 0, 0, 1, 8'hFF, 8'h01, 0);
    cycle(0, 1, 1, 1, 0, 1, 8'h7F, 8'h01, 0);
    cycle(0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
    cycle(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0);
    // Exhaustive single-bit truth table alongside an 8-bit hold test.
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      if (i == 0)
        cycle(0, 1, t[2], t[1], t[0], 1, 8'h35, 8'h4A, 1);
      else
        cycle(0, 1, t[2], t[1], t[0], 0, 8'(8'h11 * i), 8'h99, t[0]);
    end
    // Reset mid-stream with in_valid high, then first valid after release.
    cycle(0, 1, 1, 1, 1, 1, 8'h80, 8'h80, 0);
    cycle(1, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
    cycle(0, 1, 1, 0, 1, 1, 8'h12, 8'h34, 1);
    cycle(0, 0, 0, 0, 0, 0, 8'hAA, 8'h55, 0);
    // Random traffic with occasional idle cycles and resets.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(31) == 0,
            $urandom_range(3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("q1_drained", 8'(q1.size()), 8'h00);
    chk("q8_drained", 8'(q8.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
